// File: rtl/f_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory port plus the F->D pipeline fields.
// master = fetch unit (producer); slave = memory / D-stage register (consumer).
interface f_fetch_unit_if;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] F_Instr;
    logic [31:0] F_PC;
    logic [31:0] F_PC8;
    logic [4:0]  F_ExcCode;
    logic        F_BD;

    modport master (
        output im_addr,
        output F_Instr,
        output F_PC,
        output F_PC8,
        output F_ExcCode,
        output F_BD,
        input  im_rdata
    );

    modport slave (
        input  im_addr,
        input  F_Instr,
        input  F_PC,
        input  F_PC8,
        input  F_ExcCode,
        input  F_BD,
        output im_rdata
    );
endinterface

// File: rtl/f_fetch_unit.sv
// Fetch-stage PC generator with exception/eret/branch redirect, stall and AdEL detection.
// Optional macro FETCH_PERF_CNT_EN adds the perf_fetch_cnt fetch-advance counter.
module f_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT   = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        d_is_bj,
    f_fetch_unit_if.master fif
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt
`endif
);

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_NONE = 5'd0;

    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic        w_advance;
    logic        w_adel;

    // Flushes (exc_req, eret) override the stall; a stalled branch is dropped
    // because D re-presents it once the stall clears.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        w_advance = 1'b1;
        if (exc_req) begin
            w_next_pc = EXC_VECTOR;
        end else if (eret) begin
            w_next_pc = epc;
        end else if (stall) begin
            w_next_pc = r_pc;
            w_advance = 1'b0;
        end else if (br_taken) begin
            w_next_pc = br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // Bad targets are loaded as-is; the fault is reported here, not at the redirect.
    assign w_adel = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_LIMIT);

    assign fif.im_addr   = r_pc;
    assign fif.F_PC      = r_pc;
    assign fif.F_PC8     = r_pc + 32'd8;
    assign fif.F_ExcCode = w_adel ? EXC_ADEL : EXC_NONE;
    assign fif.F_Instr   = w_adel ? 32'd0 : fif.im_rdata;
    assign fif.F_BD      = d_is_bj;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_cnt <= 32'd0;
        end else if (w_advance) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_cnt;
`endif

endmodule
